i2c_phy: RTL and testbench
==========================

I2C_PHY -- requirements
Module: i2c_phy

Interface
REQ-001 SHALL have clk, input, 1, clock; rst, input, 1, reset, asynchronous, active-high.
REQ-002 SHALL have prescale, input, 17, length of each bus phase in clk cycles minus one.
REQ-003 SHALL have phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus, input, 1 each, level-sensed bit commands.
REQ-004 SHALL have phy_tx_data, input, 1, bit value for a write command.
REQ-005 SHALL have scl_i, sda_i, input, 1 each, bus line levels, already synchronised by the instantiating logic.
REQ-006 SHALL have scl_o, sda_o, output, 1 each, open-drain drive; 0 pulls the line low, 1 releases it.
REQ-007 SHALL have scl_t, sda_t, output, 1 each, tristate enables equal to scl_o and sda_o (1 = high-Z).
REQ-008 SHALL have phy_busy, bus_control_reg, phy_rx_data_reg, output, 1 each; phy_state_reg, output, 5, current state code.

Function
REQ-009 SHALL use state codes IDLE=0, ACTIVE=1, RSTART_1=2, RSTART_2=3, START_1=4, START_2=5, WRITE_1=6, WRITE_2=7, WRITE_3=8, READ_1=9, READ_2=10, READ_3=11, READ_4=12, STOP_1=13, STOP_2=14, STOP_3=15.
REQ-010 SHALL make every non-IDLE, non-ACTIVE state one phase: a counter loads prescale on entry and decrements once per clk; the phase ends on the cycle the counter reads 0. With prescale=0 the phase lasts 1 cycle; prescale=3 gives 4 cycles.
REQ-011 SHALL, in IDLE, accept only phy_start_bit (goes to START_1); other commands are ignored.
REQ-012 SHALL, in ACTIVE, act on commands with priority start (to RSTART_1) > write (to WRITE_1, latch phy_tx_data) > read (to READ_1) > stop (to STOP_1) > release_bus (to IDLE, sda_o=scl_o=1, bus_control_reg=0). The command is taken in the first ACTIVE cycle in which it is high.
REQ-013 SHALL sequence START_1 as sda_o=0 with scl released, then START_2 as scl_o=0, then ACTIVE; bus_control_reg=1 from START_1.
REQ-014 SHALL sequence RSTART_1 as sda_o=1 with scl_o=0, then RSTART_2 as scl_o=1, then START_1.
REQ-015 SHALL sequence WRITE_1 as sda_o=latched bit with scl_o=0, then WRITE_2 as scl_o=1, then WRITE_3 as scl_o=0, then ACTIVE.
REQ-016 SHALL sequence READ_1 as sda_o=1 with scl_o=0, then READ_2 and READ_3 as scl_o=1, then READ_4 as scl_o=0, then ACTIVE. sda_i is sampled into phy_rx_data_reg on the last cycle of READ_3.
REQ-017 SHALL sequence STOP_1 as sda_o=0 with scl_o=0, then STOP_2 as scl_o=1, then STOP_3 as sda_o=1, then IDLE with bus_control_reg=0.
REQ-018 SHALL hold scl_o=0 and sda unchanged in ACTIVE.
REQ-019 SHALL drive phy_busy=1 in every state except IDLE and ACTIVE.
REQ-020 SHALL register scl_o, sda_o and phy_rx_data_reg, so they are glitch-free; phy_rx_data_reg holds its value until the next read.

Reset
REQ-021 SHALL, on rst (async, any state, including mid-bit), set state=IDLE, scl_o=sda_o=1, phy_busy=0, bus_control_reg=0, phy_rx_data_reg=0 and counter=0.

Configuration
REQ-022 SHALL, with I2C_PHY_CLOCK_STRETCH_EN defined, freeze the phase counter while scl_o=1 and scl_i=0 (slave stretching); without it, scl_i SHALL be ignored.

Structure
REQ-023 SHALL place the 5-bit state enum and its codes in package i2c_phy_pkg.
REQ-024 SHALL implement the phase counter in sub-module i2c_phy_timer, with load, stall, and done signals.

Verification
REQ-025 SHALL check: prescale=3, pulse start for 1 cycle in IDLE -> sda falls while scl is high; ACTIVE after 8 cycles; bus_control_reg=1.
REQ-026 SHALL check: write bits 1,0,0,0,0,0,0,1 (0x81) -> each bit takes 12 cycles, sda is stable while scl is high, and the state returns to 1 between bits.
REQ-027 SHALL check: slave holds sda low and a read follows -> phy_rx_data_reg=0 (ACK) when ACTIVE is reached after 16 cycles; the same read with sda released -> 1 (NACK).
REQ-028 SHALL check: stop from ACTIVE -> sda rises while scl is high; IDLE; bus_control_reg=0; phy_busy=0.
REQ-029 SHALL check: assert start and write together in ACTIVE -> repeated start is taken (state=2).
REQ-030 SHALL check: hold scl_i low for 20 cycles in WRITE_2 -> the phase extends by 20 cycles when I2C_PHY_CLOCK_STRETCH_EN is defined, and does not extend without it; rst asserted mid-write -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/i2c_phy_pkg.sv
// i2c_phy_pkg: shared widths, bit-level PHY state codes and state helpers.
package i2c_phy_pkg;

    localparam int unsigned PRESCALE_W = 17;
    localparam int unsigned STATE_W    = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 5'd0,
        ST_ACTIVE   = 5'd1,
        ST_RSTART_1 = 5'd2,
        ST_RSTART_2 = 5'd3,
        ST_START_1  = 5'd4,
        ST_START_2  = 5'd5,
        ST_WRITE_1  = 5'd6,
        ST_WRITE_2  = 5'd7,
        ST_WRITE_3  = 5'd8,
        ST_READ_1   = 5'd9,
        ST_READ_2   = 5'd10,
        ST_READ_3   = 5'd11,
        ST_READ_4   = 5'd12,
        ST_STOP_1   = 5'd13,
        ST_STOP_2   = 5'd14,
        ST_STOP_3   = 5'd15
    } phy_state_e;

    // Every state other than IDLE and ACTIVE is one timed bus phase.
    function automatic logic is_phase(phy_state_e s);
        return (s != ST_IDLE) && (s != ST_ACTIVE);
    endfunction

endpackage

// File: rtl/i2c_phy_timer.sv
// i2c_phy_timer: bus phase down-counter.
//   load_i     : reload with prescale_i (phase entry)
//   stall_i    : freeze the count and hold off done
//   prescale_i : phase length in clk cycles minus one
//   done_c_o   : combinational, high on the last cycle of the phase
module i2c_phy_timer
    import i2c_phy_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  stall_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  done_c_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reload on entry, otherwise count down to zero unless stalled.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = prescale_i;
        end else if (!stall_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - PRESCALE_W'(1);
        end
    end

    assign done_c_o = (cnt_q == '0) && !stall_i;

endmodule

// File: rtl/i2c_phy.sv
// i2c_phy: I2C master bit-level PHY (start, repeated start, write, read, stop).
//   clk, rst                 : clock, async active-high reset
//   prescale                 : bus phase length in clk cycles minus one
//   phy_*_bit, release_bus   : level-sensed commands, taken in IDLE/ACTIVE
//   phy_tx_data              : bit for a write command
//   scl_i, sda_i             : synchronised bus line levels
//   scl_o/sda_o, scl_t/sda_t : registered open-drain drive (1 = release)
//   phy_busy, bus_control_reg, phy_rx_data_reg, phy_state_reg : status
// Build option: I2C_PHY_CLOCK_STRETCH_EN freezes the phase timer while a
// released scl is held low by a slave; otherwise scl_i is ignored.
module i2c_phy
    import i2c_phy_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  phy_start_bit,
    input  logic                  phy_stop_bit,
    input  logic                  phy_write_bit,
    input  logic                  phy_read_bit,
    input  logic                  phy_release_bus,
    input  logic                  phy_tx_data,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  scl_t,
    output logic                  sda_t,
    output logic                  phy_busy,
    output logic                  bus_control_reg,
    output logic                  phy_rx_data_reg,
    output logic [STATE_W-1:0]    phy_state_reg
);

    phy_state_e state_q, state_d;
    logic scl_q, scl_d;
    logic sda_q, sda_d;
    logic busy_q, busy_d;
    logic bus_ctl_q, bus_ctl_d;
    logic rx_q, rx_d;
    logic tx_bit_q, tx_bit_d;
    logic load, stall, done;

`ifdef I2C_PHY_CLOCK_STRETCH_EN
    // A slave holding a released scl low stretches the current phase.
    assign stall = scl_q & ~scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stall        = 1'b0;
`endif

    i2c_phy_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .stall_i    (stall),
        .prescale_i (prescale),
        .done_c_o   (done)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            bus_ctl_q <= 1'b0;
            rx_q      <= 1'b0;
            tx_bit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            bus_ctl_q <= bus_ctl_d;
            rx_q      <= rx_d;
            tx_bit_q  <= tx_bit_d;
        end
    end

    // Next state, then line levels for the state being entered.
    always_comb begin
        state_d   = state_q;
        tx_bit_d  = tx_bit_q;
        rx_d      = rx_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        bus_ctl_d = bus_ctl_q;

        case (state_q)
            ST_IDLE: if (phy_start_bit) state_d = ST_START_1;
            ST_ACTIVE: begin
                if (phy_start_bit) begin
                    state_d = ST_RSTART_1;
                end else if (phy_write_bit) begin
                    state_d  = ST_WRITE_1;
                    tx_bit_d = phy_tx_data;
                end else if (phy_read_bit) begin
                    state_d = ST_READ_1;
                end else if (phy_stop_bit) begin
                    state_d = ST_STOP_1;
                end else if (phy_release_bus) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RSTART_1: if (done) state_d = ST_RSTART_2;
            ST_RSTART_2: if (done) state_d = ST_START_1;
            ST_START_1:  if (done) state_d = ST_START_2;
            ST_START_2:  if (done) state_d = ST_ACTIVE;
            ST_WRITE_1:  if (done) state_d = ST_WRITE_2;
            ST_WRITE_2:  if (done) state_d = ST_WRITE_3;
            ST_WRITE_3:  if (done) state_d = ST_ACTIVE;
            ST_READ_1:   if (done) state_d = ST_READ_2;
            ST_READ_2:   if (done) state_d = ST_READ_3;
            ST_READ_3: begin
                if (done) begin
                    state_d = ST_READ_4;
                    rx_d    = sda_i;
                end
            end
            ST_READ_4:   if (done) state_d = ST_ACTIVE;
            ST_STOP_1:   if (done) state_d = ST_STOP_2;
            ST_STOP_2:   if (done) state_d = ST_STOP_3;
            ST_STOP_3:   if (done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        load   = (state_d != state_q) && is_phase(state_d);
        busy_d = is_phase(state_d);

        case (state_d)
            ST_IDLE:     begin scl_d = 1'b1; sda_d = 1'b1; bus_ctl_d = 1'b0; end
            ST_ACTIVE:   scl_d = 1'b0;
            ST_RSTART_1: begin scl_d = 1'b0; sda_d = 1'b1; end
            ST_RSTART_2: scl_d = 1'b1;
            ST_START_1:  begin scl_d = 1'b1; sda_d = 1'b0; bus_ctl_d = 1'b1; end
            ST_START_2:  scl_d = 1'b0;
            ST_WRITE_1:  begin scl_d = 1'b0; sda_d = tx_bit_d; end
            ST_WRITE_2:  scl_d = 1'b1;
            ST_WRITE_3:  scl_d = 1'b0;
            ST_READ_1:   begin scl_d = 1'b0; sda_d = 1'b1; end
            ST_READ_2:   scl_d = 1'b1;
            ST_READ_3:   scl_d = 1'b1;
            ST_READ_4:   scl_d = 1'b0;
            ST_STOP_1:   begin scl_d = 1'b0; sda_d = 1'b0; end
            ST_STOP_2:   scl_d = 1'b1;
            ST_STOP_3:   sda_d = 1'b1;
            default:     ;
        endcase
    end

    assign scl_o           = scl_q;
    assign sda_o           = sda_q;
    assign scl_t           = scl_q;
    assign sda_t           = sda_q;
    assign phy_busy        = busy_q;
    assign bus_control_reg = bus_ctl_q;
    assign phy_rx_data_reg = rx_q;
    assign phy_state_reg   = state_q;

endmodule

// File: tb/tb_i2c_phy.sv
// tb_i2c_phy: directed and randomized bit commands checked cycle by cycle
// against a phase-list model of the PHY.
module tb_i2c_phy;

    localparam int C_START = 1;
    localparam int C_WRITE = 2;
    localparam int C_READ  = 4;
    localparam int C_STOP  = 8;
    localparam int C_REL   = 16;

    typedef struct {
        int st;
        bit scl;
        bit sda;
        int len;
    } phase_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] prescale;
    logic        phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus;
    logic        phy_tx_data, scl_i, sda_i;
    logic        scl_o, sda_o, scl_t, sda_t;
    logic        phy_busy, bus_control_reg, phy_rx_data_reg;
    logic [4:0]  phy_state_reg;

    int n_vec = 0;
    int n_err = 0;

    // Model of what the bus should look like between operations.
    bit act_m = 0;
    bit bus_m = 0;
    bit rx_m  = 0;
    bit sda_m = 1;

    always #5 clk = ~clk;

    i2c_phy dut (
        .clk             (clk),
        .rst             (rst),
        .prescale        (prescale),
        .phy_start_bit   (phy_start_bit),
        .phy_stop_bit    (phy_stop_bit),
        .phy_write_bit   (phy_write_bit),
        .phy_read_bit    (phy_read_bit),
        .phy_release_bus (phy_release_bus),
        .phy_tx_data     (phy_tx_data),
        .scl_i           (scl_i),
        .sda_i           (sda_i),
        .scl_o           (scl_o),
        .sda_o           (sda_o),
        .scl_t           (scl_t),
        .sda_t           (sda_t),
        .phy_busy        (phy_busy),
        .bus_control_reg (bus_control_reg),
        .phy_rx_data_reg (phy_rx_data_reg),
        .phy_state_reg   (phy_state_reg)
    );

    function automatic logic [11:0] pk(int st, bit scl, bit sda, bit busy, bit bus, bit rx);
        return {5'(st), scl, sda, scl, sda, busy, bus, rx};
    endfunction

    function automatic logic [11:0] obs();
        return {phy_state_reg, scl_o, sda_o, scl_t, sda_t, phy_busy, bus_control_reg, phy_rx_data_reg};
    endfunction

    function automatic phase_t mk(int st, bit scl, bit sda, int len);
        phase_t p;
        p.st = st; p.scl = scl; p.sda = sda; p.len = len;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed st/scl/sda/sclt/sdat/busy/bus/rx=%b expected %b", tag, o, e);
        end
    endtask

    task automatic clear_cmds();
        phy_start_bit   = 1'b0;
        phy_stop_bit    = 1'b0;
        phy_write_bit   = 1'b0;
        phy_read_bit    = 1'b0;
        phy_release_bus = 1'b0;
    endtask

    // Issue a command set at a negedge with the PHY idle/active, then check
    // every cycle of the expected phase list and the state it settles in.
    task automatic do_op(input int cmd, input bit b, input bit sda_in, input bit stretch);
        phase_t q[$];
        int  len;
        int  k0;
        int  k;
        bit  end_idle;
        len      = int'(prescale) + 1;
        k0       = len;
        k        = 0;
        end_idle = 0;
        if (!act_m) begin
            if ((cmd & C_START) != 0) begin
                q.push_back(mk(4, 1, 0, len));
                q.push_back(mk(5, 0, 0, len));
            end else begin
                end_idle = 1;
            end
        end else if ((cmd & C_START) != 0) begin
            q.push_back(mk(2, 0, 1, len));
            q.push_back(mk(3, 1, 1, len));
            q.push_back(mk(4, 1, 0, len));
            q.push_back(mk(5, 0, 0, len));
        end else if ((cmd & C_WRITE) != 0) begin
            q.push_back(mk(6, 0, b, len));
`ifdef I2C_PHY_CLOCK_STRETCH_EN
            q.push_back(mk(7, 1, b, stretch ? len + 20 : len));
`else
            q.push_back(mk(7, 1, b, len));
`endif
            q.push_back(mk(8, 0, b, len));
        end else if ((cmd & C_READ) != 0) begin
            q.push_back(mk(9, 0, 1, len));
            q.push_back(mk(10, 1, 1, len));
            q.push_back(mk(11, 1, 1, len));
            q.push_back(mk(12, 0, 1, len));
        end else if ((cmd & C_STOP) != 0) begin
            q.push_back(mk(13, 0, 0, len));
            q.push_back(mk(14, 1, 0, len));
            q.push_back(mk(15, 1, 1, len));
            end_idle = 1;
        end else if ((cmd & C_REL) != 0) begin
            end_idle = 1;
        end

        phy_start_bit   = ((cmd & C_START) != 0);
        phy_write_bit   = ((cmd & C_WRITE) != 0);
        phy_read_bit    = ((cmd & C_READ) != 0);
        phy_stop_bit    = ((cmd & C_STOP) != 0);
        phy_release_bus = ((cmd & C_REL) != 0);
        phy_tx_data     = b;
        sda_i           = sda_in;

        foreach (q[j]) begin
            for (int i = 0; i < q[j].len; i++) begin
                @(negedge clk);
                clear_cmds();
                if (q[j].st == 12 && i == 0) rx_m = sda_in;
                if (q[j].st == 4) bus_m = 1;
                sda_m = q[j].sda;
                chk("phase", obs(), pk(q[j].st, q[j].scl, q[j].sda, 1, bus_m, rx_m));
                scl_i = !(stretch && k >= k0 && k < k0 + 20);
                k++;
            end
        end

        @(negedge clk);
        clear_cmds();
        scl_i = 1'b1;
        if (end_idle) begin
            act_m = 0; bus_m = 0; sda_m = 1;
            chk("end_idle", obs(), pk(0, 1, 1, 0, 0, rx_m));
        end else begin
            act_m = 1;
            chk("end_active", obs(), pk(1, 0, sda_m, 0, bus_m, rx_m));
        end
    endtask

    initial begin
        logic [7:0] byte_v;
        int         r;

        rst = 1'b1;
        clear_cmds();
        phy_tx_data = 1'b0;
        scl_i       = 1'b1;
        sda_i       = 1'b1;
        prescale    = 17'd3;

        // Reset values, then release reset.
        repeat (2) @(negedge clk);
        chk("reset", obs(), pk(0, 1, 1, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle", obs(), pk(0, 1, 1, 0, 0, 0));

        // Non-start commands are ignored in IDLE.
        do_op(C_WRITE, 1'b0, 1'b1, 1'b0);
        do_op(C_STOP | C_READ | C_REL, 1'b0, 1'b1, 1'b0);

        // Start: sda falls under high scl, ACTIVE after 8 cycles.
        do_op(C_START, 1'b0, 1'b1, 1'b0);

        // Write 0x81 MSB first, 12 cycles per bit.
        byte_v = 8'h81;
        for (int i = 7; i >= 0; i--) do_op(C_WRITE, byte_v[i], 1'b1, 1'b0);

        // ACK then NACK read.
        do_op(C_READ, 1'b0, 1'b0, 1'b0);
        do_op(C_READ, 1'b0, 1'b1, 1'b0);

        // Stop, then start again and a start+write collision.
        do_op(C_STOP, 1'b0, 1'b1, 1'b0);
        do_op(C_START, 1'b0, 1'b1, 1'b0);
        do_op(C_START | C_WRITE, 1'b1, 1'b1, 1'b0);

        // Randomized prescale and operations.
        for (int n = 0; n < 12; n++) begin
            prescale = 17'($urandom_range(0, 4));
            r = int'($urandom_range(0, 4));
            case (r)
                0, 1:    do_op(C_WRITE | (($urandom_range(0, 1) == 1) ? C_READ : 0),
                               1'($urandom_range(0, 1)), 1'b1, 1'b0);
                2, 3:    do_op(C_READ | (($urandom_range(0, 1) == 1) ? C_STOP : 0),
                               1'b0, 1'($urandom_range(0, 1)), 1'b0);
                default: do_op(C_START, 1'b0, 1'b1, 1'b0);
            endcase
        end

        // Release the bus, then take it again.
        do_op(C_REL, 1'b0, 1'b1, 1'b0);
        prescale = 17'd3;
        do_op(C_START, 1'b0, 1'b1, 1'b0);

        // Slave stretches scl for 20 cycles during WRITE_2.
        do_op(C_WRITE, 1'b1, 1'b1, 1'b1);
        do_op(C_WRITE, 1'b0, 1'b1, 1'b1);

        // NACK read leaves rx=1, then reset mid-write.
        do_op(C_READ, 1'b0, 1'b1, 1'b0);
        phy_write_bit = 1'b1;
        phy_tx_data   = 1'b0;
        @(negedge clk);
        clear_cmds();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", obs(), pk(0, 1, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        act_m = 0; bus_m = 0; rx_m = 0; sda_m = 1;
        @(negedge clk);
        chk("post_rst", obs(), pk(0, 1, 1, 0, 0, 0));
        do_op(C_START, 1'b0, 1'b1, 1'b0);
        do_op(C_STOP, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
